// File: rtl/ahb_manager.sv
// AHB-Lite manager: turns single-outstanding commands into AHB-Lite bursts.
// Optional AHB_MANAGER_ERR_CONTINUE_EN: resume a burst with NONSEQ after an ERROR.
module ahb_manager #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  done_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CW       = (LEN_WIDTH > 5) ? LEN_WIDTH : 5;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LAST, S_ERR, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_haddr, r_wrap_mask;
  logic [1:0]            r_htrans;
  logic                  r_hwrite;
  logic [2:0]            r_hsize, r_hburst;
  logic [CW-1:0]         r_left;
  logic                  r_dphase, r_dwrite, r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  logic [CW-1:0]         w_cmd_beats;
  logic                  w_cmd_illegal, w_cmd_wrap;
  logic [ADDR_WIDTH-1:0] w_cmd_mask, w_incr, w_addr_inc, w_addr_next;
  logic                  w_kb_cross, w_in_xfer, w_err1, w_dok, w_addr_acc;

  always_comb begin
    w_cmd_beats = CW'(1);
    case (cmd_burst[2:1])
      2'b00:   w_cmd_beats = cmd_burst[0] ? CW'(cmd_len) : CW'(1);
      2'b01:   w_cmd_beats = CW'(4);
      2'b10:   w_cmd_beats = CW'(8);
      default: w_cmd_beats = CW'(16);
    endcase
  end

  assign w_cmd_illegal = (32'(cmd_size) > MAX_SIZE) ||
                         ((cmd_burst == BU_INCR) && (cmd_len == '0));
  assign w_cmd_wrap    = !cmd_burst[0] && (cmd_burst != BU_SINGLE);
  assign w_cmd_mask    = w_cmd_wrap ?
                         ((ADDR_WIDTH'(w_cmd_beats) << cmd_size) - ADDR_WIDTH'(1)) : '1;

  // Wrapping bursts only advance the bits under the mask; all-ones mask means linear.
  assign w_incr      = ADDR_WIDTH'(1) << r_hsize;
  assign w_addr_inc  = r_haddr + w_incr;
  assign w_addr_next = (r_haddr & ~r_wrap_mask) | (w_addr_inc & r_wrap_mask);
  assign w_kb_cross  = (r_wrap_mask == '1) &&
                       (w_addr_next[ADDR_WIDTH-1:10] != r_haddr[ADDR_WIDTH-1:10]);

  assign w_in_xfer  = (r_state == S_ADDR) || (r_state == S_LAST);
  assign w_err1     = w_in_xfer && r_dphase && HRESP && !HREADY;
  assign w_dok      = w_in_xfer && r_dphase && HREADY && !HRESP;
  assign w_addr_acc = (r_state == S_ADDR) && HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_state_nxt = w_cmd_illegal ? S_LAST : S_ADDR;
      S_ADDR: begin
        if (w_err1)                            w_state_nxt = S_ERR;
        else if (w_addr_acc && r_left == '0)   w_state_nxt = S_LAST;
      end
      S_LAST: begin
        if (w_err1)                    w_state_nxt = S_ERR;
        else if (!r_dphase || w_dok)   w_state_nxt = S_DONE;
      end
      S_ERR: begin
        if (HREADY) begin
`ifdef AHB_MANAGER_ERR_CONTINUE_EN
          w_state_nxt = (r_htrans != TR_IDLE) ? S_ADDR : S_DONE;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr     <= '0;
      r_wrap_mask <= '0;
      r_htrans    <= TR_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hburst    <= '0;
      r_left      <= '0;
      r_dphase    <= 1'b0;
      r_dwrite    <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (w_dok && !r_dwrite) begin
        r_rvalid <= 1'b1;
        r_rdata  <= HRDATA;
      end
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_err    <= w_cmd_illegal;
            r_dphase <= 1'b0;
            if (!w_cmd_illegal) begin
              r_haddr     <= cmd_addr;
              r_hwrite    <= cmd_write;
              r_hsize     <= cmd_size;
              r_hburst    <= cmd_burst;
              r_htrans    <= TR_NONSEQ;
              r_left      <= w_cmd_beats - CW'(1);
              r_wrap_mask <= w_cmd_mask;
            end
          end
        end
        S_ADDR: begin
          if (w_addr_acc) begin
            r_dphase <= 1'b1;
            r_dwrite <= r_hwrite;
            if (r_left == '0) begin
              r_htrans <= TR_IDLE;
            end else begin
              r_haddr <= w_addr_next;
              r_left  <= r_left - CW'(1);
              // Crossing 1 KB restarts the burst as an undefined-length INCR.
              if (w_kb_cross) begin
                r_htrans <= TR_NONSEQ;
                r_hburst <= BU_INCR;
              end else begin
                r_htrans <= TR_SEQ;
              end
            end
          end else if (w_err1) begin
            r_err <= 1'b1;
          end
        end
        S_LAST: begin
          if (w_err1)     r_err    <= 1'b1;
          else if (w_dok) r_dphase <= 1'b0;
        end
        S_ERR: begin
          if (HREADY) begin
            r_dphase <= 1'b0;
`ifdef AHB_MANAGER_ERR_CONTINUE_EN
            if (r_htrans != TR_IDLE) begin
              r_htrans <= TR_NONSEQ;
              if (r_wrap_mask == '1) r_hburst <= BU_INCR;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // The first ERROR cycle cancels any pending address phase combinationally.
  assign HTRANS      = ((r_state == S_ADDR) && !w_err1) ? r_htrans : TR_IDLE;
  assign HADDR       = r_haddr;
  assign HWRITE      = r_hwrite;
  assign HSIZE       = r_hsize;
  assign HBURST      = r_hburst;
  assign HWDATA      = (r_dphase && r_dwrite) ? wdata : '0;
  assign wdata_ack   = w_dok && r_dwrite;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rvalid;
  assign cmd_ready   = (r_state == S_IDLE);
  assign done        = (r_state == S_DONE);
  assign done_err    = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ahb_manager.sv
// Directed self-checking bench for ahb_manager (32-bit data, word transfers).
module tb_ahb_manager;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [2:0]  cmd_burst = '0, cmd_size = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wdata = '0;
  logic        wdata_ack, rdata_valid, done, done_err, cmd_ready;
  logic [31:0] rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  logic [31:0] HRDATA = '0;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_manager #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .done_err(done_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] b,
                       input logic [2:0] s, input logic [7:0] l);
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_burst = b; cmd_size = s; cmd_len = l;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    #1;
    checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL reset_htrans got=%b exp=00", HTRANS); end
    checks++; if (HADDR !== 32'h0) begin failures++; $display("FAIL reset_haddr got=%h exp=0", HADDR); end
    checks++; if ({HWRITE, HSIZE, HBURST} !== 7'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=0", {HWRITE, HSIZE, HBURST}); end
    checks++; if (HWDATA !== 32'h0) begin failures++; $display("FAIL reset_hwdata got=%h exp=0", HWDATA); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({done, done_err, rdata_valid, wdata_ack} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {done, done_err, rdata_valid, wdata_ack}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_single_write();
    issue(1'b1, 32'h10, 3'b000, 3'd2, 8'd0);
    wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge HCLK);
      if (c == 1) cmd_valid = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0;
      #1;
      if (c == 1) begin
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h10) begin failures++; $display("FAIL sw_addr got=%b/%h exp=10/00000010", HTRANS, HADDR); end
        checks++; if ({HWRITE, HSIZE, HBURST} !== 7'b1_010_000) begin failures++; $display("FAIL sw_ctrl got=%b exp=1010000", {HWRITE, HSIZE, HBURST}); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL sw_busy got=%b exp=0", cmd_ready); end
      end
      if (c == 2) begin
        checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL sw_last_idle got=%b exp=00", HTRANS); end
        checks++; if (HWDATA !== 32'hDEADBEEF || wdata_ack !== 1'b1) begin failures++; $display("FAIL sw_data got=%h/%b exp=deadbeef/1", HWDATA, wdata_ack); end
      end
      if (c == 3) begin
        checks++; if ({done, done_err, wdata_ack} !== 3'b100) begin failures++; $display("FAIL sw_done got=%b exp=100", {done, done_err, wdata_ack}); end
      end
      if (c == 4) begin
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL sw_idle got=%b%b exp=10", cmd_ready, done); end
      end
    end
  endtask

  task automatic test_incr4_read();
    logic        hr  [8];
    logic [31:0] hd  [8];
    logic [1:0]  et  [8];
    logic [31:0] ea  [8];
    logic        erv [8];
    logic [31:0] erd [8];
    int unsigned nrv;
    hr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    hd  = '{32'h0, 32'h11111111, 32'hBAD00001, 32'hBAD00002, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0};
    et  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    ea  = '{32'h20, 32'h24, 32'h28, 32'h28, 32'h28, 32'h2C, 32'h0, 32'h0};
    erv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    erd = '{32'h0, 32'h0, 32'h11111111, 32'h0, 32'h0, 32'h22222222, 32'h33333333, 32'h44444444};
    nrv = 0;
    issue(1'b0, 32'h20, 3'b011, 3'd2, 8'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      if (i == 0) cmd_valid = 1'b0;
      HREADY = hr[i]; HRDATA = hd[i]; HRESP = 1'b0;
      #1;
      checks++; if (HTRANS !== et[i]) begin failures++; $display("FAIL i4_htrans c%0d got=%b exp=%b", i + 1, HTRANS, et[i]); end
      if (et[i] != 2'b00) begin
        checks++; if (HADDR !== ea[i] || HBURST !== 3'b011) begin failures++; $display("FAIL i4_haddr c%0d got=%h/%b exp=%h/011", i + 1, HADDR, HBURST, ea[i]); end
      end
      checks++; if (rdata_valid !== erv[i]) begin failures++; $display("FAIL i4_rvalid c%0d got=%b exp=%b", i + 1, rdata_valid, erv[i]); end
      if (erv[i]) begin
        checks++; if (rdata !== erd[i]) begin failures++; $display("FAIL i4_rdata c%0d got=%h exp=%h", i + 1, rdata, erd[i]); end
      end
      if (rdata_valid === 1'b1) nrv++;
      checks++; if (done !== (i == 7)) begin failures++; $display("FAIL i4_done c%0d got=%b exp=%b", i + 1, done, (i == 7)); end
    end
    checks++; if (nrv != 4) begin failures++; $display("FAIL i4_nbeats got=%0d exp=4", nrv); end
    HREADY = 1'b1;
  endtask

  task automatic test_wrap4_write();
    logic [31:0] wd  [6];
    logic [1:0]  et  [6];
    logic [31:0] ea  [6];
    logic [31:0] ehw [6];
    logic        eak [6];
    wd  = '{32'hA1, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
    et  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    ea  = '{32'h38, 32'h3C, 32'h30, 32'h34, 32'h0, 32'h0};
    ehw = '{32'h0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'h0};
    eak = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    issue(1'b1, 32'h38, 3'b010, 3'd2, 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (i == 0) cmd_valid = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0; wdata = wd[i];
      #1;
      checks++; if (HTRANS !== et[i]) begin failures++; $display("FAIL w4_htrans c%0d got=%b exp=%b", i + 1, HTRANS, et[i]); end
      if (et[i] != 2'b00) begin
        checks++; if (HADDR !== ea[i] || HBURST !== 3'b010) begin failures++; $display("FAIL w4_haddr c%0d got=%h/%b exp=%h/010", i + 1, HADDR, HBURST, ea[i]); end
      end
      checks++; if (HWDATA !== ehw[i] || wdata_ack !== eak[i]) begin failures++; $display("FAIL w4_wdata c%0d got=%h/%b exp=%h/%b", i + 1, HWDATA, wdata_ack, ehw[i], eak[i]); end
      checks++; if (done !== (i == 5)) begin failures++; $display("FAIL w4_done c%0d got=%b exp=%b", i + 1, done, (i == 5)); end
    end
  endtask

  task automatic test_error();
    logic        hr [12];
    logic        hs [12];
    logic [1:0]  et [12];
    logic [31:0] ea [12];
    int unsigned n;
    int unsigned edc;
`ifdef AHB_MANAGER_ERR_CONTINUE_EN
    n = 12; edc = 12;
    hr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    hs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    et = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    ea = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h0, 32'h0};
`else
    n = 6; edc = 5;
    hr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    hs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    et = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    ea = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
    issue(1'b0, 32'h0, 3'b101, 3'd2, 8'd0);
    for (int i = 0; i < 12; i++) begin
      if (i < int'(n)) begin
        @(negedge HCLK);
        if (i == 0) cmd_valid = 1'b0;
        HREADY = hr[i]; HRESP = hs[i]; HRDATA = 32'hC0DE0001 + 32'(i);
        #1;
        checks++; if (HTRANS !== et[i]) begin failures++; $display("FAIL err_htrans c%0d got=%b exp=%b", i + 1, HTRANS, et[i]); end
        if (et[i] != 2'b00) begin
          checks++; if (HADDR !== ea[i]) begin failures++; $display("FAIL err_haddr c%0d got=%h exp=%h", i + 1, HADDR, ea[i]); end
        end
        if (i == 2) begin
          checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hC0DE0002) begin failures++; $display("FAIL err_beat1 got=%b/%h exp=1/c0de0002", rdata_valid, rdata); end
        end
        if (i == 3 || i == 4) begin
          checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL err_no_rvalid c%0d got=%b exp=0", i + 1, rdata_valid); end
        end
        checks++; if (done !== (i + 1 == int'(edc))) begin failures++; $display("FAIL err_done c%0d got=%b exp=%b", i + 1, done, (i + 1 == int'(edc))); end
        if (i + 1 == int'(edc)) begin
          checks++; if (done_err !== 1'b1) begin failures++; $display("FAIL err_done_err got=%b exp=1", done_err); end
        end
      end
    end
    HREADY = 1'b1; HRESP = 1'b0;
  endtask

  task automatic test_kb_cross();
    logic [1:0]  et [6];
    logic [31:0] ea [6];
    et = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00};
    ea = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h0, 32'h0};
    issue(1'b0, 32'h3F8, 3'b001, 3'd2, 8'd4);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      if (i == 0) cmd_valid = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h5000 + 32'(i);
      #1;
      checks++; if (HTRANS !== et[i]) begin failures++; $display("FAIL kb_htrans c%0d got=%b exp=%b", i + 1, HTRANS, et[i]); end
      if (et[i] != 2'b00) begin
        checks++; if (HADDR !== ea[i] || HBURST !== 3'b001) begin failures++; $display("FAIL kb_haddr c%0d got=%h/%b exp=%h/001", i + 1, HADDR, HBURST, ea[i]); end
      end
      checks++; if (rdata_valid !== (i >= 2)) begin failures++; $display("FAIL kb_rvalid c%0d got=%b exp=%b", i + 1, rdata_valid, (i >= 2)); end
      if (i == 5) begin
        checks++; if ({done, done_err} !== 2'b10) begin failures++; $display("FAIL kb_done got=%b exp=10", {done, done_err}); end
      end
    end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(1'b1, 32'h40, 3'b000, 3'd3, 8'd0);
      else        issue(1'b0, 32'h40, 3'b001, 3'd2, 8'd0);
      for (int c = 1; c <= 3; c++) begin
        @(negedge HCLK);
        if (c == 1) cmd_valid = 1'b0;
        #1;
        checks++; if (HTRANS !== 2'b00) begin failures++; $display("FAIL ill%0d_htrans c%0d got=%b exp=00", k, c, HTRANS); end
        checks++; if ({done, done_err} !== ((c == 2) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL ill%0d_done c%0d got=%b exp=%b", k, c, {done, done_err}, ((c == 2) ? 2'b11 : 2'b00)); end
        checks++; if (cmd_ready !== (c == 3)) begin failures++; $display("FAIL ill%0d_ready c%0d got=%b exp=%b", k, c, cmd_ready, (c == 3)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h50, 3'b000, 3'd2, 8'd0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge HCLK);
      if (c == 1) begin cmd_write = 1'b1; cmd_addr = 32'h80; end
      if (c == 5) cmd_valid = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0; wdata = 32'h12345678;
      #1;
      if (c == 1) begin
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h50 || HWRITE !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b/%h/%b exp=10/00000050/0", HTRANS, HADDR, HWRITE); end
      end
      if (c == 2) begin
        checks++; if (cmd_ready !== 1'b0 || HADDR !== 32'h50) begin failures++; $display("FAIL b2b_ignore got=%b/%h exp=0/00000050", cmd_ready, HADDR); end
      end
      if (c == 3 || c == 7) begin
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done c%0d got=%b exp=1", c, done); end
      end
      if (c == 4) begin
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
      end
      if (c == 5) begin
        checks++; if (HTRANS !== 2'b10 || HADDR !== 32'h80 || HWRITE !== 1'b1) begin failures++; $display("FAIL b2b_second got=%b/%h/%b exp=10/00000080/1", HTRANS, HADDR, HWRITE); end
      end
      if (c == 6) begin
        checks++; if (wdata_ack !== 1'b1 || HWDATA !== 32'h12345678) begin failures++; $display("FAIL b2b_wdata got=%b/%h exp=1/12345678", wdata_ack, HWDATA); end
      end
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 32'h100, 3'b111, 3'd2, 8'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge HCLK);
      if (c == 1) cmd_valid = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0;
    end
    #1;
    checks++; if (HTRANS !== 2'b11 || HADDR !== 32'h108) begin failures++; $display("FAIL rm_pre got=%b/%h exp=11/00000108", HTRANS, HADDR); end
    HRESETn = 1'b0;
    #1;
    checks++; if (HTRANS !== 2'b00 || cmd_ready !== 1'b1 || HADDR !== 32'h0) begin failures++; $display("FAIL rm_async got=%b/%b/%h exp=00/1/0", HTRANS, cmd_ready, HADDR); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge HCLK);
      #1;
      checks++; if ({done, HTRANS, cmd_ready} !== 4'b0001) begin failures++; $display("FAIL rm_quiet c%0d got=%b exp=0001", c, {done, HTRANS, cmd_ready}); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read();
    test_wrap4_write();
    test_error();
    test_kb_cross();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
